uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Shares one UART transmitter (uart_tx plus BAUD_GENERATE) between NUM_REQ requesters using round-robin arbitration.
- Accepts one byte per grant over a valid/ready handshake and issues a one-cycle start pulse to the transmitter.
- Gates the baud generator enable so it runs only while a frame is in flight.
- Waits for the transmitter's done tick, then enforces an idle gap before the next grant.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BITWIDTH, 8, data bits per frame
GAP_CYCLES, 16, clk cycles of forced idle after each frame (0 allowed: straight back to IDLE)
TIMEOUT_CYCLES, 200000, clk cycles allowed in WAIT before abort (used only with UART_TX_SCHED_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte-valid
req_data  in  NUM_REQ*BITWIDTH  packed bytes; requester i at [i*BITWIDTH +: BITWIDTH]
req_ready  out  NUM_REQ  one-hot accept, combinational in IDLE
tx_start  out  1  one-cycle start pulse to transmitter
tx_din  out  BITWIDTH  registered byte to transmitter, held stable START..WAIT
tx_done_tick  in  1  transmitter end-of-frame pulse
baud_enable  out  1  enable to BAUD_GENERATE
busy  out  1  high in every state except IDLE
grant_id  out  clog2(NUM_REQ)  index of requester currently being served
timeout_err  out  1  one-cycle abort pulse (constant 0 without the macro)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; round-robin pointer=0, so requester 0 has highest priority first. Reset mid-frame aborts at once, and the interrupted byte is lost.
- States: IDLE, START, WAIT, GAP. Registered 2-bit encoding.
- IDLE:
  - req_ready = one-hot of the first asserted req_valid, searching from the pointer upward with wrap.
  - On valid&ready at the clock edge: tx_din<=req_data[winner], grant_id<=winner, pointer<=winner+1 (mod NUM_REQ), state<=START.
  - No valid: stay in IDLE, req_ready=0.
- START: tx_start=1 and baud_enable=1 for exactly one cycle, then go to WAIT.
- WAIT: baud_enable=1, req_ready=0.
  - On tx_done_tick=1, go to GAP (or IDLE if GAP_CYCLES=0).
- GAP: baud_enable=0; count GAP_CYCLES cycles, then go to IDLE. Counter is cleared on entry.
- Latency: accept edge to tx_start high = 1 cycle. Done tick to next possible accept = GAP_CYCLES+1 cycles.
- tx_done_tick in IDLE, START or GAP is ignored.
- req_valid deasserted before acceptance: no effect, nothing is latched. Requesters must hold req_data stable while req_valid=1.
- Fairness: a requester holding valid continuously waits at most NUM_REQ-1 frames.
- Widths: counters sized clog2(max(GAP_CYCLES,TIMEOUT_CYCLES)+1), saturating and never wrapping.

Optional Feature:
UART_TX_SCHED_TIMEOUT_EN
- Defined:
  - A WAIT-state counter starts at 0 on entry.
  - If it reaches TIMEOUT_CYCLES-1 without tx_done_tick: timeout_err=1 for one cycle, state goes to GAP, baud_enable drops.
  - If tx_done_tick and the timeout occur in the same cycle, the done tick wins and timeout_err stays 0.
- Undefined: no counter; WAIT lasts indefinitely; timeout_err is tied to 0. The port list is identical either way.

Decomposition:
- Shared header uart_defs: BITWIDTH default, state encodings (IDLE=0, START=1, WAIT=2, GAP=3), clog2 function.
- One sub-module, rr_arbiter: combinational priority picker taking req_valid and the pointer, returning a one-hot grant and its index.
- Scheduler FSM, data register and counters stay in uart_tx_scheduler.

Test Plan:
- Reset, then req_valid=4'b0001, byte 8'hA5 -> req_ready=4'b0001 in the same cycle; tx_start one cycle later with tx_din=8'hA5, grant_id=0; baud_enable=1 until the done tick.
- All four requesters valid, bytes 8'h10..8'h13 held -> service order 0,1,2,3,0; each tx_start separated by (frame time + GAP_CYCLES+1) cycles.
- After requester 2 is served, req_valid=4'b0101 -> requester 0 is granted (pointer=3, wraps past 3 to 0), not requester 2.
- Assert reset_n=0 mid-WAIT -> tx_start, baud_enable and busy drop to 0 asynchronously; after release, req_valid=4'b0010 is granted with pointer=0 search order.
- tx_done_tick pulsed during GAP and IDLE -> no state change and no extra tx_start.
- Macro defined, TIMEOUT_CYCLES=50, done tick withheld -> timeout_err high exactly one cycle, 50 cycles after entering WAIT, then GAP then IDLE. Macro undefined, same stimulus -> stays in WAIT, timeout_err=0.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: default frame width,
// FSM state encoding and constant helper functions.
package uart_tx_scheduler_pkg;

  localparam int BITWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping around, returned as a one-hot grant plus its index.
module uart_tx_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int w_pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    w_pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= NUM_REQ) begin
        w_pos = w_pos - NUM_REQ;
      end
      if (!grant_any && req_valid[w_pos]) begin
        grant_any    = 1'b1;
        grant[w_pos] = 1'b1;
        grant_idx    = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters.
// Optional WAIT-state abort is enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int BITWIDTH       = BITWIDTH_DEF,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BITWIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [BITWIDTH-1:0]          tx_din,
  input  logic                         tx_done_tick,
  output logic                         baud_enable,
  output logic                         busy,
  output logic [clog2(NUM_REQ)-1:0]    grant_id,
  output logic                         timeout_err
);

  localparam int IDX_W   = clog2(NUM_REQ);
  localparam int CNT_MAX = max2(GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = max2(1, clog2(CNT_MAX + 1));
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_t          r_state;
  sched_state_t          w_state_next;
  logic [BITWIDTH-1:0]   r_tx_din;
  logic [IDX_W-1:0]      r_grant_id;
  logic [IDX_W-1:0]      r_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_accept;
  logic                  w_timeout;
  logic [NUM_REQ-1:0]    w_grant;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_any;
  logic [IDX_W-1:0]      w_ptr_next;
  logic [BITWIDTH-1:0]   w_req_bytes [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_bytes[gi] = req_data[gi*BITWIDTH +: BITWIDTH];
  end

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_win_idx),
    .grant_any (w_any)
  );

  assign w_ptr_next = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_accept     = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: w_state_next = ST_WAIT;
      ST_WAIT: begin
        // A done tick landing on the timeout cycle takes precedence.
        if (tx_done_tick) begin
          w_state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
`ifdef UART_TX_SCHED_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_GAP;
        end
`endif
      end
      ST_GAP: begin
        if (r_cnt >= GAP_LAST) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_tx_din   <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_tx_din   <= w_req_bytes[w_win_idx];
        r_grant_id <= w_win_idx;
        r_ptr      <= w_ptr_next;
      end
      // Shared WAIT/GAP counter restarts on every state change and saturates.
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic r_timeout_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  assign req_ready   = (r_state == ST_IDLE) ? w_grant : '0;
  assign tx_start    = (r_state == ST_START);
  assign baud_enable = (r_state == ST_START) || (r_state == ST_WAIT);
  assign busy        = (r_state != ST_IDLE);
  assign tx_din      = r_tx_din;
  assign grant_id    = r_grant_id;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of arbitration vectors plus
// hand-written sequences for gap timing, reset abort and WAIT timeout.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int BW   = 8;
  localparam int GAP  = 4;
  localparam int TO   = 50;
  localparam int F    = 6;

  logic            clk;
  logic            reset_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*BW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            tx_start;
  logic [BW-1:0]   tx_din;
  logic            tx_done_tick;
  logic            baud_enable;
  logic            busy;
  logic [1:0]      grant_id;
  logic            timeout_err;

  int checks;
  int failures;
  int cycle;

  uart_tx_scheduler #(
    .NUM_REQ(NREQ), .BITWIDTH(BW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din),
    .tx_done_tick(tx_done_tick), .baud_enable(baud_enable), .busy(busy),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Called in START: runs F WAIT cycles, then the done tick moves the DUT to GAP.
  task automatic finish_frame();
    step();
    chk("wait_ready_low", 32'(req_ready), 32'h0);
    chk("wait_baud", 32'(baud_enable), 32'h1);
    chk("wait_start_low", 32'(tx_start), 32'h0);
    repeat (F - 1) step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
  endtask

  task automatic gap_phase(input bit poke_done);
    chk("gap_baud_low", 32'(baud_enable), 32'h0);
    for (int i = 0; i < GAP - 1; i++) begin
      if (poke_done && i == 1) tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      chk("gap_busy", 32'(busy), 32'h1);
      chk("gap_no_start", 32'(tx_start), 32'h0);
    end
    step();
    chk("gap_end_idle", 32'(busy), 32'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk("idle_reached", 32'(busy), 32'h0);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tx_start !== 1'b1 && n < 200);
    chk("start_seen", 32'(tx_start), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    int n;
    bit flag;
    checks = 0; failures = 0; cycle = 0;
    reset_n = 1'b0; req_valid = '0; req_data = '0; tx_done_tick = 1'b0;

    vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 8'hA5};
    vecs[1] = '{4'b1111, 32'h13121110, 4'b0010, 2'd1, 8'h11};
    vecs[2] = '{4'b1111, 32'h13121110, 4'b0100, 2'd2, 8'h12};
    vecs[3] = '{4'b0101, 32'h13121110, 4'b0001, 2'd0, 8'h10};
    vecs[4] = '{4'b1111, 32'h13121110, 4'b0010, 2'd1, 8'h11};
    vecs[5] = '{4'b1000, 32'h13121110, 4'b1000, 2'd3, 8'h13};
    vecs[6] = '{4'b1111, 32'h13121110, 4'b0001, 2'd0, 8'h10};
    vecs[7] = '{4'b0001, 32'h13121110, 4'b0001, 2'd0, 8'h10};
    vecs[8] = '{4'b1100, 32'h13121110, 4'b0100, 2'd2, 8'h12};
    vecs[9] = '{4'b1100, 32'h13121110, 4'b1000, 2'd3, 8'h13};

    #3;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_start", 32'(tx_start), 32'h0);
    chk("rst_din", 32'(tx_din), 32'h0);
    chk("rst_baud", 32'(baud_enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);
    step(); step();
    #2 reset_n = 1'b1;

    // Table: each vector starts from IDLE and runs a full frame plus gap.
    for (int k = 0; k < 10; k++) begin
      req_valid = vecs[k].valid;
      req_data  = vecs[k].data;
      #1;
      chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
      step();
      chk($sformatf("v%0d_start", k), 32'(tx_start), 32'h1);
      chk($sformatf("v%0d_grant", k), 32'(grant_id), 32'(vecs[k].exp_grant));
      chk($sformatf("v%0d_din", k), 32'(tx_din), 32'(vecs[k].exp_din));
      chk($sformatf("v%0d_baud", k), 32'(baud_enable), 32'h1);
      chk($sformatf("v%0d_busy", k), 32'(busy), 32'h1);
      req_valid = '0;
      finish_frame();
      gap_phase(k == 2);
    end

    // All four held: order 0,1,2,3,0 with fixed start-to-start spacing.
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_start();
      if (i > 0) chk("held_period", 32'(cycle - prev), 32'(F + GAP + 2));
      prev = cycle;
      chk($sformatf("held%0d_grant", i), 32'(grant_id), 32'(i % 4));
      chk($sformatf("held%0d_din", i), 32'(tx_din), 32'(8'h10 + (i % 4)));
      finish_frame();
      if (i == 4) req_valid = '0;
    end
    wait_idle();

    // Done tick while idle must not start anything.
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("idle_tick_busy", 32'(busy), 32'h0);
    step();
    chk("idle_tick_nostart", 32'(tx_start), 32'h0);

    // Reset mid-WAIT: pointer is 1 here, serving requester 2 moves it to 3.
    req_valid = 4'b0100;
    step();
    chk("rstw_grant", 32'(grant_id), 32'h2);
    req_valid = '0;
    step(); step(); step();
    chk("rstw_in_wait", 32'(baud_enable), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_start", 32'(tx_start), 32'h0);
    chk("rstw_baud", 32'(baud_enable), 32'h0);
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_din", 32'(tx_din), 32'h0);
    chk("rstw_gid", 32'(grant_id), 32'h0);
    step(); step();
    #2 reset_n = 1'b1;
    req_valid = 4'b0011;
    req_data  = 32'h13121110;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    chk("post_rst_grant", 32'(grant_id), 32'h0);
    chk("post_rst_din", 32'(tx_din), 32'h10);
    req_valid = '0;
    finish_frame();
    wait_idle();

    // Done tick withheld in WAIT; pointer is 1 so requester 1 is served.
    req_valid = 4'b0010;
    step();
    chk("to_grant", 32'(grant_id), 32'h1);
    req_valid = '0;
    step();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    n = 0;
    flag = 1'b0;
    while (n < 80 && !flag) begin
      step();
      n++;
      if (timeout_err === 1'b1) flag = 1'b1;
    end
    chk("to_latency", 32'(n), 32'(TO));
    chk("to_baud_low", 32'(baud_enable), 32'h0);
    chk("to_busy_gap", 32'(busy), 32'h1);
    step();
    chk("to_pulse_width", 32'(timeout_err), 32'h0);
    wait_idle();
`else
    flag = 1'b0;
    n = 0;
    repeat (TO + 10) begin
      step();
      n++;
      if (timeout_err !== 1'b0) flag = 1'b1;
    end
    chk("no_timeout_err", 32'(flag), 32'h0);
    chk("still_wait_baud", 32'(baud_enable), 32'h1);
    chk("still_wait_busy", 32'(busy), 32'h1);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    wait_idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
